router_1xn_core: RTL and testbench



---
 rtl/router_1xn_core_pkg.sv | 33 +++
 rtl/router_1xn_core_if.sv | 26 ++
 rtl/router_1xn_core_fifo.sv | 92 +++++++++
 rtl/router_1xn_core.sv | 174 +++++++++++++++++
 tb/tb_router_1xn_core.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/router_1xn_core_pkg.sv
// Shared types and helpers for the 1-to-N packet router: FSM state
// encoding, address-width sizing and header field extraction.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_HDR = 2'd1,
        LOAD   = 2'd2,
        DROP   = 2'd3
    } state_t;

    // Widest header word the field helpers accept; WIDTH must not exceed it.
    localparam int HDR_MAX_W = 64;

    // Address field width: enough bits to name every port, never zero.
    function automatic int addr_w(input int num_ports);
        return (num_ports <= 2) ? 1 : $clog2(num_ports);
    endfunction

    // Destination address lives in the low aw bits of the header.
    function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                      input int aw);
        return hdr & ((64'd1 << aw) - 64'd1);
    endfunction

    // Payload length occupies the header bits above the address field.
    function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                     input int aw,
                                                     input int width);
        return (hdr >> aw) & ((64'd1 << (width - aw)) - 64'd1);
    endfunction

endpackage

// File: rtl/router_1xn_core_if.sv
// Source/destination bus of the router: framed source words with a stall
// back to the driver, and per-destination read request / valid / data.
interface router_1xn_core_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 3
);
    logic                       pkt_valid;
    logic [WIDTH-1:0]           data_in;
    logic                       busy;
    logic                       error;
    logic [NUM_PORTS-1:0]       read_enb;
    logic [NUM_PORTS-1:0]       vld_out;
    logic [NUM_PORTS*WIDTH-1:0] data_out;

    // Environment side: drives packets and read requests.
    modport master (
        output pkt_valid, data_in, read_enb,
        input  busy, error, vld_out, data_out
    );

    // Router side.
    modport slave (
        input  pkt_valid, data_in, read_enb,
        output busy, error, vld_out, data_out
    );
endinterface

// File: rtl/router_1xn_core_fifo.sv
// One destination FIFO of the router with a registered read port and an
// idle-destination timeout that flushes the whole FIFO when it expires.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_flush,
    output logic [WIDTH-1:0] o_dout
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [TMO_W-1:0] r_tmo;
    logic [WIDTH-1:0] r_dout;

    logic w_empty;
    logic w_full;
    logic w_flush;
    logic w_do_wr;
    logic w_do_rd;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    // The timer reaches TIMEOUT on this edge, so the flush lands on it too
    // and vld_out drops on the following cycle.
    assign w_flush = !w_empty && !i_rd && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_do_rd = i_rd && !w_empty;
    // A flush discards everything, including a word arriving on the same edge.
    assign w_do_wr = i_wr && !w_full && !w_flush;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_flush = w_flush;
    assign o_dout  = r_dout;

    // Storage array: written only, no reset needed.
    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, occupancy, read register and idle timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tmo    <= '0;
            r_dout   <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tmo    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_empty || i_rd) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

endmodule

// File: rtl/router_1xn_core.sv
// 1-to-N packet router: parses header/payload/parity frames from a single
// source, steers each frame into the addressed destination FIFO, checks
// parity and reports bad address, truncation and timeout flushes.
module router_1xn_core
    import router_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic             clock,
    input  logic             reset_n,
    router_1xn_core_if.slave bus
);
    localparam int ADDR_W = addr_w(NUM_PORTS);
    localparam int LEN_W  = WIDTH - ADDR_W;

    state_t           r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_error;
    logic [WIDTH-1:0]  r_hdr;
    logic [WIDTH-1:0]  r_parity;

    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_flush;
    logic [NUM_PORTS-1:0] w_wr;
    logic                 w_full_tgt;
    logic                 w_flush_tgt;
    logic                 w_busy;
    logic                 w_wr_en;
    logic [WIDTH-1:0]     w_wr_data;
    logic [ADDR_W-1:0]    w_hdr_addr;
    logic [LEN_W-1:0]     w_hdr_len;
    logic                 w_addr_bad;
    logic                 w_accept;

    assign w_hdr_addr = ADDR_W'(hdr_addr(HDR_MAX_W'(bus.data_in), ADDR_W));
    assign w_hdr_len  = LEN_W'(hdr_len(HDR_MAX_W'(bus.data_in), ADDR_W, WIDTH));
    assign w_addr_bad = (int'(w_hdr_addr) >= NUM_PORTS);

    // Flags of the FIFO currently being filled.
    always_comb begin
        w_full_tgt  = 1'b0;
        w_flush_tgt = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_full_tgt  = w_full[i];
                w_flush_tgt = w_flush[i];
            end
        end
    end

    // Stall and write strobe depend only on state and FIFO flags, never on data_in.
    always_comb begin
        w_busy    = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_data = bus.data_in;
        case (r_state)
            WR_HDR: begin
                w_busy    = 1'b1;
                w_wr_en   = !w_full_tgt;
                w_wr_data = r_hdr;
            end
            LOAD: begin
                w_busy  = w_full_tgt;
                w_wr_en = bus.pkt_valid && !w_full_tgt;
            end
            default: begin
                w_busy  = 1'b0;
                w_wr_en = 1'b0;
            end
        endcase
    end

    assign w_accept = (r_state == LOAD) && bus.pkt_valid && !w_full_tgt && !w_flush_tgt;

    // Packet framing FSM with registered error pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.pkt_valid) begin
                        r_addr <= w_hdr_addr;
                        r_len  <= w_hdr_len;
                        r_cnt  <= '0;
                        if (w_addr_bad) begin
                            r_state <= DROP;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= WR_HDR;
                        end
                    end
                end
                WR_HDR: begin
                    if (w_flush_tgt) begin
                        r_state <= DROP;
                        r_error <= 1'b1;
                    end else if (!w_full_tgt) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_flush_tgt) begin
                        r_state <= DROP;
                        r_error <= 1'b1;
                    end else if (!bus.pkt_valid) begin
                        r_state <= IDLE;
                        r_error <= 1'b1;
                    end else if (!w_full_tgt) begin
                        if (r_cnt == r_len) begin
                            r_state <= IDLE;
                            r_error <= (bus.data_in != r_parity);
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (!bus.pkt_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Header copy and running parity; always reloaded before use, so no reset.
    always_ff @(posedge clock) begin
        if ((r_state == IDLE) && bus.pkt_valid) begin
            r_hdr    <= bus.data_in;
            r_parity <= bus.data_in;
        end else if (w_accept && (r_cnt != r_len)) begin
            r_parity <= r_parity ^ bus.data_in;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic w_empty;

        assign w_wr[g]         = w_wr_en && (r_addr == ADDR_W'(g));
        assign bus.vld_out[g]  = !w_empty;

        router_fifo #(
            .WIDTH      (WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .TIMEOUT    (TIMEOUT)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .i_wr    (w_wr[g]),
            .i_din   (w_wr_data),
            .i_rd    (bus.read_enb[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty),
            .o_flush (w_flush[g]),
            .o_dout  (bus.data_out[g*WIDTH +: WIDTH])
        );
    end

    assign bus.busy  = w_busy;
    assign bus.error = r_error;

endmodule

// File: tb/tb_router_1xn_core.sv
// Directed bench for router_1xn_core with default parameters.
module tb_router_1xn_core;

    logic clock;
    logic reset_n;

    int n_cmp;
    int n_err;
    int err_pulses;

    logic [7:0] pkt4 [22];
    logic [7:0] par4;
    int sent;
    int rd;
    int guard;
    logic acc;
    logic pop;

    router_1xn_core_if #(.WIDTH(8), .NUM_PORTS(3)) bus ();

    router_1xn_core #(
        .WIDTH      (8),
        .NUM_PORTS  (3),
        .FIFO_DEPTH (16),
        .TIMEOUT    (30)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.error === 1'b1) err_pulses++;
    endtask

    task automatic send_word(input logic [7:0] w);
        int g;
        g = 0;
        bus.pkt_valid = 1'b1;
        bus.data_in   = w;
        while (bus.busy && g < 100) begin
            tick();
            g++;
        end
        check("busy_wait", bus.busy, 1'b0);
        tick();
    endtask

    task automatic read_word(input int port, input logic [7:0] exp, input string tag);
        bus.read_enb       = '0;
        bus.read_enb[port] = 1'b1;
        tick();
        bus.read_enb = '0;
        check(tag, bus.data_out[port*8 +: 8], exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        err_pulses = 0;
        reset_n = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = '0;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_error", bus.error, 1'b0);
        check("rst_vld", bus.vld_out, 3'b000);
        check("rst_dout", bus.data_out, 24'h0);
        reset_n = 1'b1;
        tick();

        // good packet to port 1
        err_pulses = 0;
        send_word(8'h0D); send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h0D);
        bus.pkt_valid = 1'b0;
        tick();
        check("t1_vld", bus.vld_out, 3'b010);
        read_word(1, 8'h0D, "t1_rd0");
        read_word(1, 8'h11, "t1_rd1");
        read_word(1, 8'h22, "t1_rd2");
        read_word(1, 8'h33, "t1_rd3");
        read_word(1, 8'h0D, "t1_rd4");
        check("t1_vld_empty", bus.vld_out, 3'b000);
        read_word(1, 8'h0D, "t1_rd_empty_hold");
        check("t1_no_err", err_pulses, 0);

        // bad parity
        err_pulses = 0;
        send_word(8'h0D); send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'hFF);
        check("t2_err_pulse", bus.error, 1'b1);
        bus.pkt_valid = 1'b0;
        tick();
        check("t2_err_clear", bus.error, 1'b0);
        check("t2_err_once", err_pulses, 1);
        check("t2_vld", bus.vld_out, 3'b010);
        read_word(1, 8'h0D, "t2_rd0");
        read_word(1, 8'h11, "t2_rd1");
        read_word(1, 8'h22, "t2_rd2");
        read_word(1, 8'h33, "t2_rd3");
        read_word(1, 8'hFF, "t2_rd4");

        // bad address 3
        err_pulses = 0;
        send_word(8'h07);
        check("t3_err", bus.error, 1'b1);
        check("t3_busy0", bus.busy, 1'b0);
        send_word(8'hAA);
        check("t3_busy1", bus.busy, 1'b0);
        send_word(8'hAD);
        bus.pkt_valid = 1'b0;
        tick();
        tick();
        check("t3_vld", bus.vld_out, 3'b000);
        check("t3_err_once", err_pulses, 1);

        // long packet to port 0, back-pressure
        err_pulses = 0;
        pkt4[0] = 8'h50;
        par4 = 8'h50;
        for (int i = 1; i <= 20; i++) begin
            pkt4[i] = 8'(i);
            par4 = par4 ^ 8'(i);
        end
        pkt4[21] = par4;
        for (int i = 0; i < 16; i++) send_word(pkt4[i]);
        check("t4_busy_full", bus.busy, 1'b1);
        bus.data_in  = pkt4[16];
        bus.read_enb = 3'b001;
        tick();
        bus.read_enb = 3'b000;
        check("t4_pop_hdr", bus.data_out[7:0], 8'h50);
        check("t4_busy_drop", bus.busy, 1'b0);
        sent = 16;
        rd = 1;
        guard = 0;
        while ((rd < 22) && (guard < 200)) begin
            bus.pkt_valid = (sent < 22);
            bus.data_in   = (sent < 22) ? pkt4[sent] : 8'h00;
            bus.read_enb  = {2'b00, bus.vld_out[0]};
            acc = (sent < 22) && !bus.busy;
            pop = bus.vld_out[0];
            tick();
            if (acc) sent++;
            if (pop) begin
                check("t4_data", bus.data_out[7:0], pkt4[rd]);
                rd++;
            end
            guard++;
        end
        bus.read_enb  = '0;
        bus.pkt_valid = 1'b0;
        check("t4_all_read", rd, 22);
        check("t4_no_err", err_pulses, 0);

        // unread port 2 times out
        err_pulses = 0;
        send_word(8'h06); send_word(8'h5A); send_word(8'h5C);
        bus.pkt_valid = 1'b0;
        repeat (20) tick();
        check("t5_vld_held", bus.vld_out, 3'b100);
        repeat (20) tick();
        check("t5_vld_flushed", bus.vld_out, 3'b000);
        check("t5_dout", bus.data_out[23:16], 8'h00);
        check("t5_no_err", err_pulses, 0);

        // reset mid-packet, then clean packet to port 0
        err_pulses = 0;
        send_word(8'h0D); send_word(8'h11);
        bus.data_in = 8'h22;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_busy", bus.busy, 1'b0);
        check("t6_error", bus.error, 1'b0);
        check("t6_vld", bus.vld_out, 3'b000);
        check("t6_dout", bus.data_out, 24'h0);
        bus.pkt_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        send_word(8'h08); send_word(8'hC3); send_word(8'h3C); send_word(8'hF7);
        bus.pkt_valid = 1'b0;
        tick();
        check("t6_vld_new", bus.vld_out, 3'b001);
        read_word(0, 8'h08, "t6_rd0");
        read_word(0, 8'hC3, "t6_rd1");
        read_word(0, 8'h3C, "t6_rd2");
        read_word(0, 8'hF7, "t6_rd3");
        check("t6_no_err", err_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
